// File: rtl/data_mem_if_if.sv
// data_mem_if_if: load/store request, response and RAM port bundle.
// master = core side, slave = adapter side, ram = byte-write RAM side.
interface data_mem_if_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [3:0]            mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_di;
  logic [31:0]           mem_dout;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_di,
    input  mem_dout
  );

  modport ram (
    input  mem_we, mem_addr, mem_di,
    output mem_dout
  );
endinterface

// File: rtl/data_mem_if.sv
// data_mem_if: load/store adapter for a 4x8 byte-write RAM with
// registered read. Ports: clk, rstn (async low), bus (slave modport:
// req_*/rsp_* core channel, mem_* RAM port). One request in flight,
// IDLE->ISSUE->CAPTURE. `define DATA_MEM_IF_MISALIGN_CHK_EN enables
// misalign/illegal-size errors; otherwise offsets are masked.
module data_mem_if #(
  parameter int ADDR_WIDTH = 32
) (
  input logic          clk,
  input logic          rstn,
  data_mem_if_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_di_q, mem_di_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [1:0]  req_off;
  logic [1:0]  req_size;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_di;

  always_comb begin
    req_off  = bus.req_addr[1:0];
    req_size = bus.req_size;
    req_err  = 1'b0;
`ifdef DATA_MEM_IF_MISALIGN_CHK_EN
    unique case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_off[0];
      2'b10:   req_err = |req_off;
      default: req_err = 1'b1;
    endcase
`else
    // size 11 behaves as word; low offset bits are ignored
    if (req_size == 2'b11) req_size = 2'b10;
    if (req_size == 2'b01) req_off[0] = 1'b0;
    if (req_size == 2'b10) req_off = 2'b00;
`endif
    unique case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_off;
        req_di = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = 4'b0011 << req_off;
        req_di = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        req_be = 4'b1111;
        req_di = bus.req_wdata;
      end
    endcase
    if (!bus.req_we || req_err) req_be = 4'b0000;
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = bus.mem_dout[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? bus.mem_dout[31:16]
                       : bus.mem_dout[15:0];
    unique case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_byte[7]}},
                          ld_byte};
      2'b01:   ld_data = {{16{~uns_q & ld_half[15]}},
                          ld_half};
      default: ld_data = bus.mem_dout;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_di_d    = mem_di_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d      = req_off;
          size_d     = req_size;
          uns_d      = bus.req_unsigned;
          we_d       = bus.req_we;
          err_d      = req_err;
          mem_we_d   = req_be;
          mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_di_d   = req_di;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        mem_we_d = 4'b0000;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (we_q || err_q) ? 32'h0 : ld_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_di_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_di_q    <= mem_di_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_di    = mem_di_q;

endmodule

// File: tb/tb_data_mem_if.sv
// tb_data_mem_if: directed plan plus random loads/stores checked
// against a byte-array memory model; includes a mid-store reset.
module tb_data_mem_if;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  data_mem_if_if #(.ADDR_WIDTH(32)) bus ();

  data_mem_if #(.ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [16] = '{default: 32'h0};
  logic [3:0]  ridx;
  assign ridx = bus.mem_addr[5:2];

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (bus.mem_we[j])
        ram[ridx][8*j +: 8] <= bus.mem_di[8*j +: 8];
    bus.mem_dout <= ram[ridx];
  end

  logic [7:0] mdl [64];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input logic junk,
                      output logic [31:0] rd);
    int          nb;
    int          n;
    int          base;
    logic [1:0]  off;
    logic        err;
    logic [3:0]  e_we;
    logic [31:0] e_di;
    logic [31:0] v;
    off = a[1:0];
    err = 1'b0;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DATA_MEM_IF_MISALIGN_CHK_EN
    err = (sz == 2'd3) || (sz == 2'd1 && off[0])
       || (sz == 2'd2 && off != 2'd0);
`else
    if (nb == 2) off[0] = 1'b0;
    if (nb == 4) off = 2'd0;
`endif
    base = int'(a[5:2]) * 4 + int'(off);
    e_we = (nb == 1) ? 4'b0001 : (nb == 2) ? 4'b0011 : 4'b1111;
    e_we = e_we << off;
    if (!we || err) e_we = 4'b0000;
    e_di = (nb == 1) ? {4{wd[7:0]}} :
           (nb == 2) ? {2{wd[15:0]}} : wd;
    v = 32'h0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(mdl[base + i]) << (8 * i));
    if (!uns && nb == 1 && v[7])  v[31:8]  = '1;
    if (!uns && nb == 2 && v[15]) v[31:16] = '1;
    if (we || err) v = 32'h0;

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
    if (we && !err) check("mem_di", bus.mem_di, e_di);
    check("rsp_idle", 32'(bus.rsp_valid), 32'h0);
    if (junk) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = $urandom_range(0, 63);
      bus.req_wdata = $urandom;
    end
    @(posedge clk); #1;
    check("mem_we_clr", 32'(bus.mem_we), 32'h0);
    check("rsp_early", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    check("rsp_rdata", bus.rsp_rdata, v);
    rd = bus.rsp_rdata;
    if (we && !err)
      for (int i = 0; i < nb; i++)
        mdl[base + i] = wd[8*i +: 8];
  endtask

  logic [31:0] rd;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mdl[i] = 8'h0;
    rstn             = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_rvalid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.rsp_err), 32'h0);
    check("rst_we", 32'(bus.mem_we), 32'h0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_di", bus.mem_di, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int w = 0; w < 16; w++)
      xfer(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, rd);

    xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("plan_ldw", rd, 32'hDEADBEEF);
    xfer(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 1'b0, rd);
    xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("plan_ldw2", rd, 32'hA5ADBEEF);
    xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, rd);
    check("plan_lbs", rd, 32'hFFFFFFA5);
    xfer(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, rd);
    check("plan_lbu", rd, 32'h000000A5);
    xfer(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, rd);
    check("plan_lhs", rd, 32'hFFFFA5AD);
    xfer(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, rd);
    xfer(1'b1, 2'd2, 1'b0, 32'h11, 32'h11223344, 1'b0, rd);
    xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
`ifdef DATA_MEM_IF_MISALIGN_CHK_EN
    check("plan_misal", rd, 32'h1234BEEF);
`else
    check("plan_misal", rd, 32'h11223344);
`endif

    for (int k = 0; k < 80; k++)
      xfer(1'($urandom), 2'($urandom), 1'($urandom),
           32'($urandom_range(0, 63)), $urandom,
           1'($urandom), rd);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort_we", 32'(bus.mem_we), 32'hF);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_we0", 32'(bus.mem_we), 32'h0);
    check("abort_rv", 32'(bus.rsp_valid), 32'h0);
    check("abort_rdy", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_norsp", 32'(bus.rsp_valid), 32'h0);
    end
    check("abort_rdy2", 32'(bus.req_ready), 32'h1);

    for (int w = 0; w < 16; w++)
      xfer(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, 1'b0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_if.md
# data_mem_if

Initiator-side adapter between the core's load/store request channel and the single-port byte-write data RAM (4 × 8-bit columns, registered read, read-first). Converts byte/half/word loads and stores into column write strobes, lane-replicated write data and a word-aligned address. It also extracts and sign/zero-extends load data from the RAM's one-cycle-latency read port. One request is in flight at a time; each request returns exactly one response pulse.

## Interface
- ADDR_WIDTH, 32, byte-address width of request and memory address
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  adapter can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal size or misaligned access
- mem_we  out  4  column write strobes
- mem_addr  out  ADDR_WIDTH  byte address with [1:0] forced to 00
- mem_di  out  32  lane-replicated write data
- mem_dout  in  32  RAM read data, valid one cycle after the address edge

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → IDLE. No other transitions.
- IDLE: req_ready=1. Accept on req_valid at edge N.
  - Register off=req_addr[1:0], size, unsigned, we, err.
  - Register mem_addr={req_addr[AW-1:2],2'b00}.
  - Register mem_di and mem_we. Go to ISSUE.
- Store strobes:
  - byte: 0001<<off
  - half: 0011<<off
  - word: 1111
  - load or err: 0000
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- ISSUE: RAM samples mem_addr/mem_we at edge N+1. Clear mem_we at that edge. Go to CAPTURE.
- CAPTURE: mem_dout holds the word. At edge N+2 register rsp_valid=1 and rsp_rdata. Go to IDLE.
- rsp_rdata for loads:
  - byte: mem_dout[8*off+:8], extended to 32
  - half: mem_dout[16*off[1]+:16], extended to 32
  - word: mem_dout as is
- rsp_rdata is 0 for stores and errors.
- Error condition: size 11, half with off[0]=1, or word with off≠00.
- On error:
  - mem_we stays 0000 (no RAM modification).
  - Response timing is unchanged; rsp_err=1, rsp_rdata=0.
- req_valid is ignored outside IDLE. No response backpressure; rsp_valid is a single-cycle pulse.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0000, mem_addr=0, mem_di=0, state IDLE.
- Latency: accept at edge N, response valid in the cycle after edge N+2.
- Back-to-back: next accept no earlier than edge N+3, giving one transaction per 3 cycles.
- mem_we is high for exactly one cycle, between edges N and N+1.
- Reset asserted mid-transaction:
  - Outputs clear immediately (asynchronous).
  - A pending strobe is dropped, so no write occurs at the next edge.
  - No response is emitted for the aborted request.
- Reset deassertion: first accept possible at the first rising edge with rstn=1.

## Configuration
- DATA_MEM_IF_MISALIGN_CHK_EN defined: misalignment and illegal size are detected and reported as described above.
- Macro undefined:
  - Offset bits below the access size are masked: half uses off&2'b10, word uses 2'b00.
  - Size 11 is treated as word.
  - rsp_err is tied to 0.
  - The access proceeds normally.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10:
  - Store: mem_we=1111 for one cycle, rsp_err=0.
  - Load: rsp_rdata=0xDEADBEEF two edges after accept.
- Store byte 0xA5 to 0x13:
  - mem_we=1000, mem_di=0xA5A5A5A5.
  - Word load from 0x10 returns 0xA5ADBEEF.
- Load byte from 0x13:
  - signed: rsp_rdata=0xFFFFFFA5
  - unsigned: 0x000000A5
- Load half from 0x12, signed, returns 0xFFFFA5AD. Store half 0x1234 to 0x12: mem_we=1100.
- Misaligned word store to 0x11 with the macro defined:
  - mem_we stays 0000, rsp_err=1, rsp_rdata=0, memory unchanged.
  - With the macro undefined: a write to 0x10 occurs with mem_we=1111.
- Assert rstn low in ISSUE of a store:
  - mem_we drops immediately, no rsp_valid, target word unchanged.
  - req_ready=1 after release.
